// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator:
// FSM state encodings and the sequential PC increment.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PC_ST_BOOT = 2'd0,
    PC_ST_RUN  = 2'd1,
    PC_ST_PEND = 2'd2
  } pc_st_e;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_gen_mispredict_check.sv
// Combinational branch resolution check.
// Ports: i_ex_* resolution bundle in; o_mispredict, o_correct_pc out.
module mispredict_check
  import pc_gen_pkg::*;
(
  input  logic        i_ex_valid,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  output logic        o_mispredict,
  output logic [31:0] o_correct_pc
);

  logic w_dir_wrong;
  logic w_tgt_wrong;

  assign w_dir_wrong = i_ex_taken != i_ex_pred_taken;
  // A wrong target only matters when both sides agree on taken.
  assign w_tgt_wrong = i_ex_taken & i_ex_pred_taken &
                       (i_ex_target != i_ex_pred_target);

  assign o_mispredict = i_ex_valid & (w_dir_wrong | w_tgt_wrong);
  assign o_correct_pc = i_ex_taken ? i_ex_target
                                   : i_ex_pc + PC_INC;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register, redirect arbiter and branch counters.
// Ports: stall/dec/ex redirect inputs; pc, squash pulses, counters out.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             dec_valid,
  input  logic [31:0]      target,
  input  logic             target_taken,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic [31:0]      pc,
  output logic             pc_valid,
  output logic             kill_fetch,
  output logic             flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  pc_st_e            r_st;
  pc_st_e            w_st_nxt;
  logic [31:0]       r_pc;
  logic [31:0]       w_pc_nxt;
  logic [31:0]       r_pend_pc;
  logic [31:0]       w_pend_nxt;
  logic              r_flush;
  logic              w_flush_nxt;
  logic              r_kill;
  logic              w_kill_nxt;
  logic [CNT_W-1:0]  r_br;
  logic [CNT_W-1:0]  r_mis;
  logic              w_mis;
  logic [31:0]       w_cpc;

  mispredict_check u_chk (
    .i_ex_valid       (ex_valid),
    .i_ex_pc          (ex_pc),
    .i_ex_pred_taken  (ex_pred_taken),
    .i_ex_pred_target (ex_pred_target),
    .i_ex_taken       (ex_taken),
    .i_ex_target      (ex_target),
    .o_mispredict     (w_mis),
    .o_correct_pc     (w_cpc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st      <= PC_ST_BOOT;
      r_pc      <= RESET_PC;
      r_pend_pc <= '0;
      r_flush   <= 1'b0;
      r_kill    <= 1'b0;
    end else begin
      r_st      <= w_st_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_nxt;
      r_flush   <= w_flush_nxt;
      r_kill    <= w_kill_nxt;
    end
  end

  always_comb begin
    w_st_nxt    = r_st;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend_pc;
    w_flush_nxt = 1'b0;
    w_kill_nxt  = 1'b0;
    unique case (r_st)
      PC_ST_BOOT: w_st_nxt = PC_ST_RUN;
      PC_ST_RUN, PC_ST_PEND: begin
        if (!stall) begin
          w_st_nxt = PC_ST_RUN;
          // Live mispredict is younger than pend.
          if (w_mis) begin
            w_pc_nxt    = w_cpc;
            w_flush_nxt = 1'b1;
          end else if (r_st == PC_ST_PEND) begin
            w_pc_nxt    = r_pend_pc;
            w_flush_nxt = 1'b1;
          end else if (dec_valid && target_taken) begin
            w_pc_nxt   = target;
            w_kill_nxt = 1'b1;
          end else begin
            w_pc_nxt = r_pc + PC_INC;
          end
        end else if (w_mis) begin
          // Hold pc; remember the redirect.
          w_st_nxt   = PC_ST_PEND;
          w_pend_nxt = w_cpc;
        end
      end
      default: w_st_nxt = PC_ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br  <= '0;
      r_mis <= '0;
    end else begin
      if (ex_valid && !(&r_br))
        r_br <= r_br + CNT_W'(1);
      if (w_mis && !(&r_mis))
        r_mis <= r_mis + CNT_W'(1);
    end
  end

  assign pc            = r_pc;
  assign pc_valid      = r_st != PC_ST_BOOT;
  assign kill_fetch    = r_kill;
  assign flush         = r_flush;
  assign br_count      = r_br;
  assign mispred_count = r_mis;

endmodule

// File: tb/tb_pc_gen.sv
// Randomized bench for pc_gen with a behavioural reference model.
// Directed scenarios pin the model; a negedge process compares.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, dec_valid, target_taken;
  logic [31:0] target;
  logic        ex_valid, ex_pred_taken, ex_taken;
  logic [31:0] ex_pc, ex_pred_target, ex_target;

  logic [31:0] pc, s_pc;
  logic        pc_valid, s_pc_valid;
  logic        kill_fetch, s_kill;
  logic        flush, s_flush;
  logic [31:0] br_count, mispred_count;
  logic [3:0]  s_br, s_mis;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_gen u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .dec_valid(dec_valid), .target(target),
    .target_taken(target_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .pc(pc), .pc_valid(pc_valid),
    .kill_fetch(kill_fetch), .flush(flush),
    .br_count(br_count),
    .mispred_count(mispred_count)
  );

  pc_gen #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .dec_valid(dec_valid), .target(target),
    .target_taken(target_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .pc(s_pc), .pc_valid(s_pc_valid),
    .kill_fetch(s_kill), .flush(s_flush),
    .br_count(s_br), .mispred_count(s_mis)
  );

  // Reference model state
  logic        m_boot = 1'b1;
  logic [31:0] m_pc = 32'h4000_0000;
  logic        m_flush = 1'b0;
  logic        m_kill = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_pend_pc = '0;
  longint      m_br = 0;
  longint      m_mis = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v,
                                 input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1;
    m_pc = 32'h4000_0000;
    m_flush = 1'b0;
    m_kill = 1'b0;
    m_pend = 1'b0;
    m_pend_pc = '0;
    m_br = 0;
    m_mis = 0;
  endtask

  always @(posedge clk) begin
    logic        mp;
    logic [31:0] cp;
    if (rst_n) begin
      mp = ex_valid && ((ex_taken != ex_pred_taken) ||
           (ex_taken && ex_pred_taken &&
            ex_target != ex_pred_target));
      cp = ex_taken ? ex_target : ex_pc + 32'd4;
      m_flush = 1'b0;
      m_kill = 1'b0;
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (!stall) begin
        if (mp) begin
          m_pc = cp; m_flush = 1'b1; m_pend = 1'b0;
        end else if (m_pend) begin
          m_pc = m_pend_pc; m_flush = 1'b1;
          m_pend = 1'b0;
        end else if (dec_valid && target_taken) begin
          m_pc = target; m_kill = 1'b1;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end else if (mp) begin
        m_pend = 1'b1; m_pend_pc = cp;
      end
      if (ex_valid) m_br++;
      if (mp) m_mis++;
    end
  end

  always @(negedge clk) begin
    chk("pc", {32'd0, pc}, {32'd0, m_pc});
    chk("pc_valid", {63'd0, pc_valid}, {63'd0, !m_boot});
    chk("kill", {63'd0, kill_fetch}, {63'd0, m_kill});
    chk("flush", {63'd0, flush}, {63'd0, m_flush});
    chk("br", {32'd0, br_count}, sat(m_br, 32));
    chk("mis", {32'd0, mispred_count}, sat(m_mis, 32));
    chk("s_pc", {32'd0, s_pc}, {32'd0, m_pc});
    chk("s_br", {60'd0, s_br}, sat(m_br, 4));
    chk("s_mis", {60'd0, s_mis}, sat(m_mis, 4));
  end

  task automatic idle();
    stall = 0; dec_valid = 0; target_taken = 0;
    target = '0; ex_valid = 0; ex_pc = '0;
    ex_pred_taken = 0; ex_pred_target = '0;
    ex_taken = 0; ex_target = '0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    chk(nm, {32'd0, act}, {32'd0, exp});
  endtask

  initial begin
    idle();
    model_reset();
    step();
    lit("t1_rst_pc", pc, 32'h4000_0000);
    lit("t1_rst_v", {31'd0, pc_valid}, 32'd0);
    rst_n = 1;
    lit("t1_boot_v", {31'd0, pc_valid}, 32'd0);
    step();
    lit("t1_run_v", {31'd0, pc_valid}, 32'd1);
    lit("t1_pc0", pc, 32'h4000_0000);
    step();
    lit("t1_pc1", pc, 32'h4000_0004);
    step();
    lit("t1_pc2", pc, 32'h4000_0008);

    dec_valid = 1; target_taken = 1;
    target = 32'h0000_2FFC;
    step();
    lit("t2_pc", pc, 32'h0000_2FFC);
    lit("t2_kill", {31'd0, kill_fetch}, 32'd1);
    lit("t2_flush", {31'd0, flush}, 32'd0);
    idle();
    step();
    lit("t2_kill_end", {31'd0, kill_fetch}, 32'd0);
    lit("t2_pc_nxt", pc, 32'h0000_3000);

    ex_valid = 1; ex_pc = 32'h0000_3000;
    ex_pred_taken = 0; ex_taken = 1;
    ex_target = 32'h0000_3040;
    dec_valid = 1; target_taken = 1;
    target = 32'h0000_5000;
    step();
    lit("t3_pc", pc, 32'h0000_3040);
    lit("t3_flush", {31'd0, flush}, 32'd1);
    lit("t3_kill", {31'd0, kill_fetch}, 32'd0);
    lit("t3_br", br_count, 32'd1);
    lit("t3_mis", mispred_count, 32'd1);
    idle();
    step();
    lit("t3_flush_end", {31'd0, flush}, 32'd0);
    lit("t3_pc_nxt", pc, 32'h0000_3044);

    stall = 1; ex_valid = 1; ex_pc = 32'h0000_1000;
    ex_pred_taken = 1; ex_taken = 0;
    ex_pred_target = 32'h0000_2000;
    ex_target = 32'h0000_2000;
    step();
    lit("t4_hold0", pc, 32'h0000_3044);
    lit("t4_noflush", {31'd0, flush}, 32'd0);
    lit("t4_mis", mispred_count, 32'd2);
    idle(); stall = 1;
    step();
    step();
    lit("t4_hold2", pc, 32'h0000_3044);
    stall = 0;
    step();
    lit("t4_pc", pc, 32'h0000_1004);
    lit("t4_flush", {31'd0, flush}, 32'd1);
    step();
    lit("t4_flush_end", {31'd0, flush}, 32'd0);
    lit("t4_pc_nxt", pc, 32'h0000_1008);

    dec_valid = 1; target_taken = 1;
    target = 32'hFFFF_FFFC;
    step();
    lit("t5_top", pc, 32'hFFFF_FFFC);
    idle();
    step();
    lit("t5_wrap", pc, 32'h0000_0000);
    ex_valid = 1; ex_pc = 32'hFFFF_FFFC;
    ex_pred_taken = 1; ex_taken = 0;
    step();
    lit("t5_cpc", pc, 32'h0000_0000);
    lit("t5_flush", {31'd0, flush}, 32'd1);

    idle();
    for (int i = 0; i < 20; i++) begin
      ex_valid = 1; ex_taken = 1; ex_pred_taken = 0;
      ex_pc = 32'h100 + 32'(i) * 4;
      ex_target = 32'h0000_0100;
      step();
    end
    idle();
    lit("t6_sbr", {28'd0, s_br}, 32'h0000_000F);
    lit("t6_smis", {28'd0, s_mis}, 32'h0000_000F);
    lit("t6_br", br_count, 32'd23);
    lit("t6_mis", mispred_count, 32'd23);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 249) == 0) begin
        #2;
        rst_n = 0;
        model_reset();
        #1;
        lit("rnd_arst_pc", pc, 32'h4000_0000);
        lit("rnd_arst_v", {31'd0, pc_valid}, 32'd0);
        idle();
        @(negedge clk);
        #1;
        rst_n = 1;
      end else begin
        stall = ($urandom_range(0, 9) < 3);
        dec_valid = $urandom_range(0, 1) == 1;
        target_taken = $urandom_range(0, 2) == 0;
        target = $urandom;
        ex_valid = $urandom_range(0, 2) == 0;
        ex_pc = $urandom;
        ex_pred_taken = $urandom_range(0, 1) == 1;
        ex_taken = $urandom_range(0, 1) == 1;
        ex_target = $urandom;
        ex_pred_target = ($urandom_range(0, 1) == 1)
                         ? ex_target : $urandom;
      end
    end
    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
